jtkcpu_intctl: RTL and testbench
================================

Name: jtkcpu_intctl

Overview:
- Interrupt and exception controller for the KCPU core.
- Synchronises the nmi_n/firq_n/irq_n pins, edge-detects NMI, applies CC masking and fixed priority, and issues one service request at a time to the microcode sequencer.
- Sequences reset-vector entry and CWAI/SYNC wake-up.
- Drives intvec and the push-all selection consumed by the control unit and the stack engine.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per interrupt pin (allowed range 1..3)

Ports:
rst  input  1  asynchronous active-high reset
clk  input  1  clock
cen  input  1  clock enable; all state advances only when cen=1
nmi_n  input  1  NMI pin, falling-edge triggered
firq_n  input  1  FIRQ pin, level, active low
irq_n  input  1  IRQ pin, level, active low
cc  input  8  condition codes; bit6=F mask, bit4=I mask
s_wr  input  1  pulse: S register written (arms NMI)
int_ack  input  1  microcode accepts request at instruction boundary
int_done  input  1  microcode has loaded PC from vector
wait_go  input  1  pulse: enter wait (CWAI or SYNC)
wait_sync  input  1  qualifies wait_go: 1=SYNC, 0=CWAI
int_req  output  1  service request pending
intvec  output  4  vector address low nibble: E reset, C NMI, 8 IRQ, 6 FIRQ
psh_all  output  1  1 = push entire state (reset/NMI/IRQ), 0 = PC+CC only (FIRQ)
intsrv  output  1  high from int_ack until int_done
wake  output  1  one-cen pulse ending a wait
nmi_armed  output  1  NMI enabled flag

Behaviour:
- Reset values: int_req=1, intvec=4'hE, psh_all=1, intsrv=0, wake=0, nmi_armed=0, state=RST, nmi_pend=0, synchronisers=all 1.
- Reset asserted mid-service or mid-wait returns everything to the reset values immediately.
- Synchroniser: SYNC_STAGES flops per pin, clocked on cen.
- NMI edge detect: a falling edge is a 1→0 transition of the synchronised NMI between consecutive cen cycles.
  - When nmi_armed=1, the edge sets nmi_pend.
  - When nmi_armed=0, the edge is discarded.
- nmi_armed sets on the first s_wr after reset and never clears except on rst.
- Request qualifiers:
  - nmi_q = nmi_pend
  - firq_q = ~firq_s & ~cc[6]
  - irq_q = ~irq_s & ~cc[4]
  - Priority: NMI > FIRQ > IRQ.
- States and transitions:
  - RST: int_req=1, intvec=E. int_ack → SERVE (type reset).
  - IDLE: int_req = nmi_q|firq_q|irq_q. intvec/psh_all combinationally track the highest-priority qualifier. wait_go → WAIT. int_ack with int_req=1 → SERVE.
  - SERVE:
    - On entry, the type is latched into intvec/psh_all.
    - intsrv=1, int_req=0.
    - If the type is NMI, nmi_pend clears in the same cen cycle as int_ack. An NMI edge in that same cycle sets nmi_pend again (set wins).
    - int_done → IDLE.
    - New requests stay pending and re-raise int_req the cycle after returning to IDLE.
  - WAIT: int_req=0.
    - CWAI: exit when any of nmi_q|firq_q|irq_q is true.
    - SYNC: exit when nmi_pend, or firq_s=0, or irq_s=0, regardless of masks.
    - Exit pulses wake for one cen cycle and goes to IDLE. Any qualified request then raises int_req on the next cen.
- int_ack while int_req=0 is ignored.
- int_done outside SERVE is ignored.
- wait_go outside IDLE is ignored.
- Latency, pin low to int_req high: SYNC_STAGES cen cycles for FIRQ/IRQ, SYNC_STAGES+1 for NMI (edge register).
- Mask change: masking by cc takes effect combinationally in IDLE. A request dropping before int_ack is withdrawn without side effects.
- Masks never affect the latched type in SERVE.
- All outputs are registered except int_req, intvec and psh_all in IDLE.

Test Plan:
- Reset release, then int_ack, then int_done: int_req=1 and intvec=E from reset; intsrv=1 after ack; idle with int_req=0 after done (lines high).
- NMI before arming: pulse nmi_n low with no s_wr → int_req stays 0. Then s_wr and another falling edge → int_req=1, intvec=C, psh_all=1 after 3 cen (SYNC_STAGES=2).
- Priority and masking: cc=8'h00, firq_n=0 and irq_n=0 → intvec=6, psh_all=0. cc=8'h40 → intvec=8, psh_all=1. cc=8'h50 → int_req=0.
- Nesting: NMI edge during SERVE of IRQ → int_req stays 0 until int_done, then int_req=1, intvec=C the next cen.
- CWAI vs SYNC: cc=8'h10, irq_n=0.
  - wait_go with wait_sync=0 → no wake.
  - wait_go with wait_sync=1 → wake pulse after SYNC_STAGES cen, then IDLE with int_req=0.
- Simultaneous int_ack (NMI) and a new NMI edge → nmi_pend remains 1; after int_done a second NMI request with intvec=C.

Source files
------------

// File: rtl/jtkcpu_intctl.sv
// KCPU interrupt/exception controller: pin synchronisers, NMI edge detection,
// CC masking with fixed priority, reset-vector entry and CWAI/SYNC wake-up.
module jtkcpu_intctl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       nmi_n,
    input  logic       firq_n,
    input  logic       irq_n,
    input  logic [7:0] cc,
    input  logic       s_wr,
    input  logic       int_ack,
    input  logic       int_done,
    input  logic       wait_go,
    input  logic       wait_sync,
    output logic       int_req,
    output logic [3:0] intvec,
    output logic       psh_all,
    output logic       intsrv,
    output logic       wake,
    output logic       nmi_armed
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_IDLE,
        ST_SERVE,
        ST_WAIT
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] nmi_sync_q, firq_sync_q, irq_sync_q;
    logic                   nmi_prev_q;
    logic                   nmi_pend_q, nmi_pend_d;
    logic                   armed_q;
    logic [3:0]             vec_q;
    logic                   psh_q;
    logic                   intsrv_q;
    logic                   wake_q;
    logic                   wsync_q;

    logic       nmi_s, firq_s, irq_s;
    logic       nmi_edge, nmi_take;
    logic       firq_qual, irq_qual, any_req;
    logic       wake_cond;
    logic [3:0] pri_vec;
    logic       pri_psh;
    logic       unused_cc;

    assign unused_cc = ^{cc[7], cc[5], cc[3:0]};

    assign nmi_s  = nmi_sync_q[SYNC_STAGES-1];
    assign firq_s = firq_sync_q[SYNC_STAGES-1];
    assign irq_s  = irq_sync_q[SYNC_STAGES-1];

    assign nmi_edge  = nmi_prev_q & ~nmi_s;
    assign firq_qual = ~firq_s & ~cc[6];
    assign irq_qual  = ~irq_s & ~cc[4];
    assign any_req   = nmi_pend_q | firq_qual | irq_qual;

    // SYNC wakes on raw synchronised pins, ignoring the CC masks
    assign wake_cond = wsync_q ? (nmi_pend_q | ~firq_s | ~irq_s) : any_req;

    // An edge arriving in the same cycle the NMI is taken keeps it pending
    assign nmi_take   = (state_q == ST_IDLE) & int_ack & nmi_pend_q;
    assign nmi_pend_d = (nmi_edge & armed_q) | (nmi_pend_q & ~nmi_take);

    always_comb begin
        pri_vec = 4'h8;
        pri_psh = 1'b1;
        if (nmi_pend_q) begin
            pri_vec = 4'hC;
            pri_psh = 1'b1;
        end else if (firq_qual) begin
            pri_vec = 4'h6;
            pri_psh = 1'b0;
        end
    end

    always_comb begin
        int_req = (state_q == ST_RST) | ((state_q == ST_IDLE) & any_req);
        intvec  = (state_q == ST_IDLE) ? pri_vec : vec_q;
        psh_all = (state_q == ST_IDLE) ? pri_psh : psh_q;
    end

    assign intsrv    = intsrv_q;
    assign wake      = wake_q;
    assign nmi_armed = armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RST;
            nmi_sync_q  <= '1;
            firq_sync_q <= '1;
            irq_sync_q  <= '1;
            nmi_prev_q  <= 1'b1;
            nmi_pend_q  <= 1'b0;
            armed_q     <= 1'b0;
            vec_q       <= 4'hE;
            psh_q       <= 1'b1;
            intsrv_q    <= 1'b0;
            wake_q      <= 1'b0;
            wsync_q     <= 1'b0;
        end else if (cen) begin
            nmi_sync_q  <= SYNC_STAGES'({nmi_sync_q, nmi_n});
            firq_sync_q <= SYNC_STAGES'({firq_sync_q, firq_n});
            irq_sync_q  <= SYNC_STAGES'({irq_sync_q, irq_n});
            nmi_prev_q  <= nmi_s;
            nmi_pend_q  <= nmi_pend_d;
            wake_q      <= 1'b0;
            if (s_wr) armed_q <= 1'b1;

            case (state_q)
                ST_RST: begin
                    if (int_ack) begin
                        state_q  <= ST_SERVE;
                        vec_q    <= 4'hE;
                        psh_q    <= 1'b1;
                        intsrv_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (int_ack && any_req) begin
                        state_q  <= ST_SERVE;
                        vec_q    <= pri_vec;
                        psh_q    <= pri_psh;
                        intsrv_q <= 1'b1;
                    end else if (wait_go) begin
                        state_q <= ST_WAIT;
                        wsync_q <= wait_sync;
                    end
                end
                ST_SERVE: begin
                    if (int_done) begin
                        state_q  <= ST_IDLE;
                        intsrv_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wake_cond) begin
                        state_q <= ST_IDLE;
                        wake_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkcpu_intctl.sv
// Self-checking bench for jtkcpu_intctl: directed scenarios with literal
// expectations plus randomized traffic compared cycle by cycle to a model.
module tb_jtkcpu_intctl;

    localparam int unsigned SS = 2;

    localparam int P_RST   = 0;
    localparam int P_IDLE  = 1;
    localparam int P_SERVE = 2;
    localparam int P_WAIT  = 3;

    logic       clk = 1'b0;
    logic       rst, cen, nmi_n, firq_n, irq_n;
    logic [7:0] cc;
    logic       s_wr, int_ack, int_done, wait_go, wait_sync;
    logic       int_req, psh_all, intsrv, wake, nmi_armed;
    logic [3:0] intvec;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtkcpu_intctl #(.SYNC_STAGES(SS)) dut (
        .rst      (rst),
        .clk      (clk),
        .cen      (cen),
        .nmi_n    (nmi_n),
        .firq_n   (firq_n),
        .irq_n    (irq_n),
        .cc       (cc),
        .s_wr     (s_wr),
        .int_ack  (int_ack),
        .int_done (int_done),
        .wait_go  (wait_go),
        .wait_sync(wait_sync),
        .int_req  (int_req),
        .intvec   (intvec),
        .psh_all  (psh_all),
        .intsrv   (intsrv),
        .wake     (wake),
        .nmi_armed(nmi_armed)
    );

    // Model: each pin's synchronised value is simply the pin as it was SS
    // enabled clocks ago, kept in a delay-line queue (front = oldest).
    bit       hn[$], hf[$], hi[$];
    bit       m_prev, m_armed, m_pend, m_srv, m_wake, m_wsync, m_psh;
    int       m_phase;
    bit [3:0] m_vec;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        hn.delete(); hf.delete(); hi.delete();
        for (int i = 0; i < int'(SS); i++) begin
            hn.push_back(1'b1); hf.push_back(1'b1); hi.push_back(1'b1);
        end
        m_prev = 1; m_armed = 0; m_pend = 0; m_srv = 0; m_wake = 0;
        m_wsync = 0; m_phase = P_RST; m_vec = 4'hE; m_psh = 1;
    endtask

    // Highest-priority pending source as (vector, push-all), or none.
    task automatic pick(output bit req, output bit [3:0] v, output bit p);
        bit fq, iq;
        fq = !hf[0] && !cc[6];
        iq = !hi[0] && !cc[4];
        req = m_pend || fq || iq;
        if (m_pend)  begin v = 4'hC; p = 1; end
        else if (fq) begin v = 4'h6; p = 0; end
        else         begin v = 4'h8; p = 1; end
    endtask

    task automatic compare();
        bit r; bit [3:0] v; bit p;
        bit e_req;
        if (rst) model_reset();
        pick(r, v, p);
        if (m_phase == P_RST)       e_req = 1;
        else if (m_phase == P_IDLE) e_req = r;
        else                        e_req = 0;
        if (m_phase != P_IDLE) begin v = m_vec; p = m_psh; end
        check("int_req", int_req, e_req);
        check("intsrv", intsrv, m_srv);
        check("wake", wake, m_wake);
        check("nmi_armed", nmi_armed, m_armed);
        if (e_req || m_phase == P_SERVE) begin
            check("intvec", intvec, v);
            check("psh_all", psh_all, p);
        end
    endtask

    task automatic model_step();
        bit r; bit [3:0] v; bit p;
        bit edge_seen, take, wcond;
        if (rst || !cen) return;
        pick(r, v, p);
        edge_seen = m_prev && !hn[0];
        take = 0;
        m_wake = 0;
        case (m_phase)
            P_RST: if (int_ack) begin
                m_phase = P_SERVE; m_vec = 4'hE; m_psh = 1; m_srv = 1;
            end
            P_IDLE: if (int_ack && r) begin
                m_phase = P_SERVE; m_vec = v; m_psh = p; m_srv = 1;
                take = m_pend;
            end else if (wait_go) begin
                m_phase = P_WAIT; m_wsync = wait_sync;
            end
            P_SERVE: if (int_done) begin
                m_phase = P_IDLE; m_srv = 0;
            end
            default: begin
                wcond = m_wsync ? (m_pend || !hf[0] || !hi[0]) : r;
                if (wcond) begin m_phase = P_IDLE; m_wake = 1; end
            end
        endcase
        if (take) m_pend = 0;
        if (edge_seen && m_armed) m_pend = 1;
        if (s_wr) m_armed = 1;
        m_prev = hn[0];
        void'(hn.pop_front()); hn.push_back(nmi_n);
        void'(hf.pop_front()); hf.push_back(firq_n);
        void'(hi.pop_front()); hi.push_back(irq_n);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1 compare();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1; cen = 1; nmi_n = 1; firq_n = 1; irq_n = 1; cc = 8'h00;
        s_wr = 0; int_ack = 0; int_done = 0; wait_go = 0; wait_sync = 0;
        model_reset();
        @(negedge clk);
        tick_n(2);
        check("rst_int_req", int_req, 1);
        check("rst_intvec", intvec, 4'hE);
        check("rst_psh_all", psh_all, 1);
        check("rst_intsrv", intsrv, 0);
        check("rst_armed", nmi_armed, 0);

        rst = 0; tick();
        int_ack = 1; tick(); int_ack = 0;
        check("rst_ack_intsrv", intsrv, 1);
        check("rst_ack_req", int_req, 0);
        int_done = 1; tick(); int_done = 0;
        check("rst_done_req", int_req, 0);
        check("rst_done_intsrv", intsrv, 0);

        nmi_n = 0; tick_n(4); nmi_n = 1; tick_n(3);
        check("nmi_unarmed", int_req, 0);
        s_wr = 1; tick(); s_wr = 0;
        check("armed", nmi_armed, 1);
        nmi_n = 0; tick_n(2);
        check("nmi_lat2", int_req, 0);
        tick();
        check("nmi_lat3_req", int_req, 1);
        check("nmi_vec", intvec, 4'hC);
        check("nmi_psh", psh_all, 1);
        int_ack = 1; tick(); int_ack = 0;
        check("nmi_srv_vec", intvec, 4'hC);
        int_done = 1; tick(); int_done = 0;
        nmi_n = 1; tick_n(3);
        check("nmi_cleared", int_req, 0);

        firq_n = 0; irq_n = 0; tick_n(2);
        check("firq_req", int_req, 1);
        check("firq_vec", intvec, 4'h6);
        check("firq_psh", psh_all, 0);
        cc = 8'h40; #1;
        check("irq_vec", intvec, 4'h8);
        check("irq_psh", psh_all, 1);
        cc = 8'h50; #1;
        check("masked_req", int_req, 0);

        cc = 8'h40; firq_n = 1;
        int_ack = 1; tick(); int_ack = 0;
        check("svc_irq_vec", intvec, 4'h8);
        nmi_n = 0; tick_n(4);
        check("nest_hold", int_req, 0);
        int_done = 1; tick(); int_done = 0;
        check("nest_req", int_req, 1);
        check("nest_vec", intvec, 4'hC);
        int_ack = 1; tick(); int_ack = 0;
        int_done = 1; tick(); int_done = 0;
        nmi_n = 1; tick_n(3);

        cc = 8'h10; wait_go = 1; wait_sync = 0; tick(); wait_go = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cwai_no_wake", wake, 0);
        end
        check("cwai_req", int_req, 0);
        cc = 8'h00; tick();
        check("cwai_wake", wake, 1);
        tick();
        check("cwai_wake_end", wake, 0);
        check("cwai_after_vec", intvec, 4'h8);

        irq_n = 1; cc = 8'h10; tick_n(3);
        wait_go = 1; wait_sync = 1; irq_n = 0; tick(); wait_go = 0;
        tick();
        check("sync_early", wake, 0);
        tick();
        check("sync_wake", wake, 1);
        check("sync_req", int_req, 0);

        irq_n = 1; cc = 8'h50; tick_n(3);
        nmi_n = 0; tick_n(3);
        check("sim_first_req", int_req, 1);
        nmi_n = 1; tick_n(3);
        nmi_n = 0; tick_n(2);
        int_ack = 1; tick(); int_ack = 0;
        check("sim_intsrv", intsrv, 1);
        int_done = 1; tick(); int_done = 0;
        check("sim_second_req", int_req, 1);
        check("sim_second_vec", intvec, 4'hC);
        int_ack = 1; tick(); int_ack = 0;
        int_done = 1; tick(); int_done = 0;
        nmi_n = 1;

        for (int n = 0; n < 4000; n++) begin
            bit [1:0] sel;
            rst       = ($urandom_range(0, 599) == 0);
            cen       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) nmi_n  = ~nmi_n;
            if ($urandom_range(0, 7) == 0) firq_n = ~firq_n;
            if ($urandom_range(0, 7) == 0) irq_n  = ~irq_n;
            if ($urandom_range(0, 15) == 0) begin
                sel = 2'($urandom_range(0, 3));
                cc  = {1'b0, sel[1], 1'b0, sel[0], 4'h0};
            end
            s_wr      = ($urandom_range(0, 199) == 0);
            int_ack   = ($urandom_range(0, 3) == 0);
            int_done  = ($urandom_range(0, 3) == 0);
            wait_go   = ($urandom_range(0, 9) == 0);
            wait_sync = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
